// File: rtl/led_pkg.sv
// Shared constants for the LED blink controller.
// LED_PWM_EN enables steady-on dimming; the duty width lives here either way.
package led_pkg;

  localparam int          N_LEDS_DEF      = 16;
  localparam int          DIV_W_DEF       = 32;
  localparam logic [31:0] HALF_PERIOD_DEF = 32'd5_555_555;
  localparam logic [15:0] BLINK_MASK_DEF  = 16'h8195;
  localparam int          DUTY_W          = 4;

  // Steady-on LEDs are lit while the free-running PWM count has not passed the duty.
  function automatic logic duty_lit(input logic [DUTY_W-1:0] pwm_cnt,
                                    input logic [DUTY_W-1:0] duty);
    return pwm_cnt <= duty;
  endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Configuration handshake bundle for led_blink_ctrl.
// Carries cfg_duty only when LED_PWM_EN is defined.
interface led_blink_ctrl_if
  import led_pkg::*;
#(
  parameter int N_LEDS = N_LEDS_DEF,
  parameter int DIV_W  = DIV_W_DEF
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [N_LEDS-1:0] cfg_blink;
  logic [N_LEDS-1:0] cfg_on;
  logic [DIV_W-1:0]  cfg_half_period;
`ifdef LED_PWM_EN
  logic [DUTY_W-1:0] cfg_duty;

  modport master (output cfg_valid, cfg_blink, cfg_on, cfg_half_period, cfg_duty,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_blink, cfg_on, cfg_half_period, cfg_duty,
                  output cfg_ready);
`else
  modport master (output cfg_valid, cfg_blink, cfg_on, cfg_half_period,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_blink, cfg_on, cfg_half_period,
                  output cfg_ready);
`endif

endinterface

// File: rtl/led_blink_ctrl_blink_divider.sv
// Half-period divider: counts clocks, toggles the blink phase and pulses tick.
// wrap_o is the combinational toggle request for the current cycle.
module blink_divider #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] half_period_i,
  input  logic             clr_i,
  output logic             phase_o,
  output logic             tick_o,
  output logic             wrap_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] hp_eff;
  logic             phase_q, tick_q;

  // A zero half-period behaves as one: toggle every cycle.
  assign hp_eff = (half_period_i == '0) ? DIV_W'(1) : half_period_i;
  assign wrap_o = (cnt_q == hp_eff - DIV_W'(1));
  assign cnt_d  = (wrap_o || clr_i) ? '0 : cnt_q + DIV_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_q ^ wrap_o;
      tick_q  <= wrap_o;
    end
  end

  assign phase_o = phase_q;
  assign tick_o  = tick_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// LED bank controller: per-LED off/steady/blink with a handshake-loaded config
// applied at blink phase boundaries. Optional LED_PWM_EN dims steady-on LEDs.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int                N_LEDS            = N_LEDS_DEF,
  parameter int                DIV_W             = DIV_W_DEF,
  parameter logic [DIV_W-1:0]  RESET_HALF_PERIOD = DIV_W'(HALF_PERIOD_DEF),
  parameter logic [N_LEDS-1:0] RESET_BLINK_MASK  = N_LEDS'(BLINK_MASK_DEF)
) (
  input  logic              clock_100mhz,
  input  logic              reset_n,
  led_blink_ctrl_if.slave   cfg,
  output logic [N_LEDS-1:0] led,
  output logic              phase,
  output logic              tick
);

  logic              pend_q;
  logic [N_LEDS-1:0] pend_blink_q, pend_on_q;
  logic [DIV_W-1:0]  pend_hp_q;

  logic [N_LEDS-1:0] act_blink_q, act_blink_d;
  logic [N_LEDS-1:0] act_on_q, act_on_d;
  logic [DIV_W-1:0]  act_hp_q, act_hp_d;

  logic [N_LEDS-1:0] led_q, led_d;
  logic              wrap, apply, accept, phase_nxt, on_lvl;

  assign cfg.cfg_ready = ~pend_q;
  assign accept        = cfg.cfg_valid & ~pend_q;
  // pend_q is registered, so a config accepted on a wrap cycle waits one more tick.
  assign apply         = wrap & pend_q;

  blink_divider #(.DIV_W(DIV_W)) u_div (
    .clk           (clock_100mhz),
    .rst_n         (reset_n),
    .half_period_i (act_hp_q),
    .clr_i         (apply),
    .phase_o       (phase),
    .tick_o        (tick),
    .wrap_o        (wrap)
  );

  assign phase_nxt = phase ^ wrap;

  always_comb begin
    act_blink_d = act_blink_q;
    act_on_d    = act_on_q;
    act_hp_d    = act_hp_q;
    if (apply) begin
      act_blink_d = pend_blink_q;
      act_on_d    = pend_on_q;
      act_hp_d    = pend_hp_q;
    end
  end

`ifdef LED_PWM_EN
  logic [DUTY_W-1:0] pend_duty_q, act_duty_q, act_duty_d, pwm_cnt_q;

  assign act_duty_d = apply ? pend_duty_q : act_duty_q;
  assign on_lvl     = duty_lit(pwm_cnt_q, act_duty_d);

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      pend_duty_q <= '0;
      act_duty_q  <= '1;
      pwm_cnt_q   <= '0;
    end else begin
      if (accept) pend_duty_q <= cfg.cfg_duty;
      act_duty_q <= act_duty_d;
      pwm_cnt_q  <= pwm_cnt_q + DUTY_W'(1);
    end
  end
`else
  assign on_lvl = 1'b1;
`endif

  // Steady-on takes priority; blink follows the phase the LEDs are about to show.
  for (genvar i = 0; i < N_LEDS; i++) begin : g_lane
    assign led_d[i] = act_on_d[i] ? on_lvl : (act_blink_d[i] & phase_nxt);
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      pend_q       <= 1'b0;
      pend_blink_q <= '0;
      pend_on_q    <= '0;
      pend_hp_q    <= '0;
      act_blink_q  <= RESET_BLINK_MASK;
      act_on_q     <= '0;
      act_hp_q     <= RESET_HALF_PERIOD;
      led_q        <= '0;
    end else begin
      if (apply) begin
        pend_q <= 1'b0;
      end else if (accept) begin
        pend_q       <= 1'b1;
        pend_blink_q <= cfg.cfg_blink;
        pend_on_q    <= cfg.cfg_on;
        pend_hp_q    <= cfg.cfg_half_period;
      end
      act_blink_q <= act_blink_d;
      act_on_q    <= act_on_d;
      act_hp_q    <= act_hp_d;
      led_q       <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed self-checking bench for led_blink_ctrl (reset half-period = 4).
module tb_led_blink_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] led;
  logic        phase, tick;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  led_blink_ctrl_if #(.N_LEDS(16), .DIV_W(32)) cfg_if ();

  led_blink_ctrl #(
    .N_LEDS(16), .DIV_W(32),
    .RESET_HALF_PERIOD(32'd4), .RESET_BLINK_MASK(16'h8195)
  ) dut (
    .clock_100mhz (clk),
    .reset_n      (reset_n),
    .cfg          (cfg_if),
    .led          (led),
    .phase        (phase),
    .tick         (tick)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [15:0] b, input logic [15:0] o, input logic [31:0] hp);
    cfg_if.cfg_valid       = 1'b1;
    cfg_if.cfg_blink       = b;
    cfg_if.cfg_on          = o;
    cfg_if.cfg_half_period = hp;
  endtask

  task automatic drop();
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Leaves time #1 after an edge; the next posedge is edge 1 after release.
  task automatic do_reset();
    drop();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    drop();
    cfg_if.cfg_blink = '0;
    cfg_if.cfg_on = '0;
    cfg_if.cfg_half_period = '0;
`ifdef LED_PWM_EN
    cfg_if.cfg_duty = 4'hF;
`endif
    reset_n = 1'b0;
    #1;
    checks++; if (led !== 16'h0000) begin failures++; $display("FAIL reset_led got=%h exp=0000", led); end
    checks++; if (phase !== 1'b0) begin failures++; $display("FAIL reset_phase got=%b exp=0", phase); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
  endtask

  task automatic test_default_blink();
    int ticks = 0;
    logic [15:0] exp;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(1);
      exp = ((k / 4) % 2 == 1) ? 16'h8195 : 16'h0000;
      checks++; if (led !== exp) begin failures++; $display("FAIL blink_led k=%0d got=%h exp=%h", k, led, exp); end
      if (tick === 1'b1) ticks++;
    end
    checks++; if (ticks != 4) begin failures++; $display("FAIL blink_ticks got=%0d exp=4", ticks); end
  endtask

  task automatic test_new_config();
    do_reset();
    offer(16'h00FF, 16'h0100, 32'd2);
    step(1);
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL cfg_ready_drop got=%b exp=0", cfg_if.cfg_ready); end
    drop();
    step(2);
    checks++; if (led !== 16'h0000) begin failures++; $display("FAIL cfg_before_tick got=%h exp=0000", led); end
    step(1);
    checks++; if (led !== 16'h01FF) begin failures++; $display("FAIL cfg_apply_led got=%h exp=01FF", led); end
    checks++; if (phase !== 1'b1 || tick !== 1'b1) begin failures++; $display("FAIL cfg_apply_phase_tick got=%b%b exp=11", phase, tick); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_ready_rise got=%b exp=1", cfg_if.cfg_ready); end
    step(1);
    checks++; if (led !== 16'h01FF || tick !== 1'b0) begin failures++; $display("FAIL cfg_hp2_hold got=%h/%b exp=01FF/0", led, tick); end
    step(1);
    checks++; if (led !== 16'h0100 || tick !== 1'b1) begin failures++; $display("FAIL cfg_hp2_off got=%h/%b exp=0100/1", led, tick); end
    step(2);
    checks++; if (led !== 16'h01FF) begin failures++; $display("FAIL cfg_hp2_on got=%h exp=01FF", led); end
  endtask

  task automatic test_offer_on_tick();
    do_reset();
    step(3);
    offer(16'h00F0, 16'h0F00, 32'd3);
    step(1);
    checks++; if (led !== 16'h8195 || tick !== 1'b1) begin failures++; $display("FAIL ontick_not_applied got=%h/%b exp=8195/1", led, tick); end
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL ontick_ready got=%b exp=0", cfg_if.cfg_ready); end
    drop();
    step(3);
    checks++; if (led !== 16'h8195) begin failures++; $display("FAIL ontick_wait got=%h exp=8195", led); end
    step(1);
    checks++; if (led !== 16'h0F00 || cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL ontick_apply got=%h/%b exp=0F00/1", led, cfg_if.cfg_ready); end
    step(2);
    checks++; if (led !== 16'h0F00) begin failures++; $display("FAIL ontick_hp3_hold got=%h exp=0F00", led); end
    step(1);
    checks++; if (led !== 16'h0FF0) begin failures++; $display("FAIL ontick_hp3_on got=%h exp=0FF0", led); end
  endtask

  task automatic test_hp_zero();
    logic [15:0] exp;
    do_reset();
    offer(16'hFFFF, 16'h0000, 32'd0);
    step(1);
    drop();
    step(3);
    checks++; if (led !== 16'hFFFF) begin failures++; $display("FAIL hp0_apply got=%h exp=FFFF", led); end
    for (int k = 5; k <= 8; k++) begin
      step(1);
      exp = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
      checks++; if (led !== exp || tick !== 1'b1) begin failures++; $display("FAIL hp0_toggle k=%0d got=%h/%b exp=%h/1", k, led, tick, exp); end
    end
    offer(16'h0001, 16'h0001, 32'd0);
    step(1);
    checks++; if (led !== 16'h0000 || cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL hp0_accept got=%h/%b exp=0000/0", led, cfg_if.cfg_ready); end
    drop();
    for (int k = 10; k <= 13; k++) begin
      step(1);
      checks++; if (led !== 16'h0001) begin failures++; $display("FAIL on_wins k=%0d got=%h exp=0001", k, led); end
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    step(3);
    offer(16'h00FF, 16'hFF00, 32'd2);
    step(3);
    checks++; if (led !== 16'h8195 || cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL midrst_pre got=%h/%b exp=8195/0", led, cfg_if.cfg_ready); end
    reset_n = 1'b0;
    #1;
    checks++; if (led !== 16'h0000 || cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL midrst_now got=%h/%b exp=0000/1", led, cfg_if.cfg_ready); end
    drop();
    step(2);
    reset_n = 1'b1;
    step(3);
    checks++; if (led !== 16'h0000) begin failures++; $display("FAIL midrst_after3 got=%h exp=0000", led); end
    step(1);
    checks++; if (led !== 16'h8195) begin failures++; $display("FAIL midrst_pattern got=%h exp=8195", led); end
    step(4);
    checks++; if (led !== 16'h0000) begin failures++; $display("FAIL midrst_hp4 got=%h exp=0000", led); end
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    int lit = 0;
    do_reset();
    offer(16'h0000, 16'h0001, 32'd4);
    cfg_if.cfg_duty = 4'h3;
    step(1);
    drop();
    step(3);
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (led[0] === 1'b1) lit++;
    end
    checks++; if (lit != 4) begin failures++; $display("FAIL pwm_duty3 lit=%0d exp=4", lit); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_default_blink();
    test_new_config();
    test_offer_on_tick();
    test_hp_zero();
    test_reset_mid_op();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
